// File: rtl/rgbv_pkg.sv
// +----------------------------------------------------------------------------
// | rgbv_pkg : shared constants, types and the double-dabble step helper
// | Rev 1.0  : initial release
// +----------------------------------------------------------------------------
`default_nettype none

package rgbv_pkg;

  localparam logic [11:0] COL_R     = 12'hF00;
  localparam logic [11:0] COL_G     = 12'h0F0;
  localparam logic [11:0] COL_B     = 12'h00F;
  localparam int          GLYPH_W   = 16;
  localparam int          ROW_PITCH = 32;

  typedef logic [11:0] bcd3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // One shift-add-3 iteration on {bcd[11:0], bin[7:0]}
  function automatic logic [19:0] dabble_step(input logic [19:0] x);
    logic [19:0] y;
    y = x;
    for (int i = 0; i < 3; i++) begin
      if (y[8+4*i +: 4] >= 4'd5)
        y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
    end
    return {y[18:0], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_value_glyph_render_bin8_bcd_seq.sv
// +----------------------------------------------------------------------------
// | bin8_bcd_seq : iterative 8-bit binary to 3-digit BCD converter, 8 cycles
// | Rev 1.0      : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module bin8_bcd_seq
  import rgbv_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output bcd3_t      bcd
);

  logic [19:0] r_sh;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic [19:0] w_next;

  assign w_next = dabble_step(r_sh);
  // done marks the cycle whose step completes; a start here chains back-to-back
  assign done   = r_busy && (r_cnt == 3'd7);
  assign bcd    = w_next[19:8];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start && (!r_busy || done)) begin
      r_sh   <= {12'd0, bin};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_sh   <= w_next;
      r_cnt  <= r_cnt + 3'd1;
      if (done)
        r_busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb_value_glyph_render.sv
// +----------------------------------------------------------------------------
// | rgb_value_glyph_render : RGB values -> BCD digits -> glyph pixels on VGA
// | Rev 1.0                : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module rgb_value_glyph_render
  import rgbv_pkg::*;
#(
  parameter logic [9:0] X0       = 10'd200,
  parameter logic [9:0] Y0       = 10'd150,
  parameter bit         BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  val_r,
  input  logic [7:0]  val_g,
  input  logic [7:0]  val_b,
  input  logic        load,
  output logic        ready,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        vidon,
  output logic [3:0]  digit_code,
  output logic [3:0]  row_addr,
  input  logic [0:15] glyph_row,
  output logic [11:0] px_rgb
);

  localparam int ROW_BITS = $clog2(ROW_PITCH);

  conv_state_t r_state;
  logic [1:0]  r_chan;
  logic [7:0]  r_lat_g;
  logic [7:0]  r_lat_b;
  bcd3_t       r_shadow [3];
  bcd3_t       r_disp   [3];

  logic        w_start;
  logic [7:0]  w_bin;
  logic        w_done;
  bcd3_t       w_bcd;

  assign w_start = ((r_state == IDLE) && load) ||
                   ((r_state == CONV) && w_done && (r_chan != 2'd2));
  assign w_bin   = (r_state == IDLE) ? val_r : ((r_chan == 2'd0) ? r_lat_g : r_lat_b);

  bin8_bcd_seq u_conv (
    .clk   (clk),
    .clr_n (clr_n),
    .start (w_start),
    .bin   (w_bin),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_chan  <= '0;
      r_lat_g <= '0;
      r_lat_b <= '0;
      ready   <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        r_shadow[i] <= '0;
        r_disp[i]   <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_lat_g <= val_g;
            r_lat_b <= val_b;
            r_chan  <= '0;
            ready   <= 1'b0;
            r_state <= CONV;
          end
        end
        CONV: begin
          if (w_done) begin
            r_shadow[r_chan] <= w_bcd;
            if (r_chan == 2'd2)
              r_state <= COMMIT;
            else
              r_chan <= r_chan + 2'd1;
          end
        end
        COMMIT: begin
          r_disp  <= r_shadow;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic        w_hit;
  logic [1:0]  w_col;
  logic [1:0]  w_row;
  bcd3_t       w_val;
  logic [3:0]  w_digit;
  logic        w_blank;

  assign w_dx  = hc - X0;
  assign w_dy  = vc - Y0;
  assign w_col = w_dx[5:4];
  assign w_row = w_dy[6:5];
  // Lower half of each 32-line row pitch is the inter-row gap
  assign w_hit = (hc >= X0) && (vc >= Y0) && (w_dx[9:6] == 4'd0) && (w_col != 2'd3) &&
                 (w_dy[9:7] == 3'd0) && !w_dy[ROW_BITS-1] && (w_row != 2'd3);

  always_comb begin
    w_val = '0;
    case (w_row)
      2'd0:    w_val = r_disp[0];
      2'd1:    w_val = r_disp[1];
      2'd2:    w_val = r_disp[2];
      default: w_val = '0;
    endcase
    w_digit = w_val[3:0];
    case (w_col)
      2'd0:    w_digit = w_val[11:8];
      2'd1:    w_digit = w_val[7:4];
      default: w_digit = w_val[3:0];
    endcase
  end

  assign w_blank = BLANK_LZ && (((w_col == 2'd0) && (w_val[11:8] == 4'd0)) ||
                                ((w_col == 2'd1) && (w_val[11:4] == 8'd0)));

  logic [$clog2(GLYPH_W)-1:0] r_bit_idx;
  logic                       r_hit;
  logic                       r_blank;
  logic                       r_vidon_d1;
  logic [1:0]                 r_pix_chan;
  logic [11:0]                w_colour;

  always_comb begin
    w_colour = COL_B;
    case (r_pix_chan)
      2'd0:    w_colour = COL_R;
      2'd1:    w_colour = COL_G;
      default: w_colour = COL_B;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      digit_code <= '0;
      row_addr   <= '0;
      r_bit_idx  <= '0;
      r_hit      <= 1'b0;
      r_blank    <= 1'b0;
      r_vidon_d1 <= 1'b0;
      r_pix_chan <= '0;
      px_rgb     <= '0;
    end else begin
      digit_code <= w_hit ? w_digit : 4'd0;
      row_addr   <= w_hit ? w_dy[3:0] : 4'd0;
      r_bit_idx  <= w_dx[3:0];
      r_hit      <= w_hit;
      r_blank    <= w_blank;
      r_vidon_d1 <= vidon;
      r_pix_chan <= w_row;
      px_rgb     <= (r_vidon_d1 && r_hit && !r_blank && glyph_row[r_bit_idx]) ? w_colour : 12'h000;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_value_glyph_render.sv
// +----------------------------------------------------------------------------
// | tb_rgb_value_glyph_render : randomized self-checking bench with value model
// | Rev 1.0                   : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_rgb_value_glyph_render;

  localparam logic [9:0] X0 = 10'd200;
  localparam logic [9:0] Y0 = 10'd150;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [7:0]  val_r, val_g, val_b;
  logic        load;
  logic        ready;
  logic [9:0]  hc, vc;
  logic        vidon;
  logic [3:0]  digit_code, row_addr;
  logic [0:15] glyph_row;
  logic [11:0] px_rgb;

  logic [0:15] rom [16][16];
  int          exp_val [3];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign glyph_row = rom[digit_code][row_addr];

  rgb_value_glyph_render #(.X0(X0), .Y0(Y0), .BLANK_LZ(1'b1)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .val_r      (val_r),
    .val_g      (val_g),
    .val_b      (val_b),
    .load       (load),
    .ready      (ready),
    .hc         (hc),
    .vc         (vc),
    .vidon      (vidon),
    .digit_code (digit_code),
    .row_addr   (row_addr),
    .glyph_row  (glyph_row),
    .px_rgb     (px_rgb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dec_digit(int val, int col);
    if (col == 0) return val / 100;
    if (col == 1) return (val / 10) % 10;
    return val % 10;
  endfunction

  // {digit, glyph row} the field presents for a position, zero outside it
  function automatic logic [7:0] model_addr(int h, int v);
    int dx = h - int'(X0);
    int dy = v - int'(Y0);
    if (dx < 0 || dx >= 48 || dy < 0 || dy >= 96 || (dy % 32) >= 16) return 8'h00;
    return {4'(dec_digit(exp_val[dy / 32], dx / 16)), 4'(dy % 16)};
  endfunction

  function automatic logic [11:0] model_px(int h, int v, bit on);
    int dx = h - int'(X0);
    int dy = v - int'(Y0);
    int col, ch, d;
    if (!on || dx < 0 || dx >= 48 || dy < 0 || dy >= 96 || (dy % 32) >= 16) return 12'h000;
    col = dx / 16;
    ch  = dy / 32;
    if (col == 0 && exp_val[ch] < 100) return 12'h000;
    if (col == 1 && exp_val[ch] < 10)  return 12'h000;
    d = dec_digit(exp_val[ch], col);
    if (!rom[d][dy % 16][dx % 16]) return 12'h000;
    return (ch == 0) ? 12'hF00 : (ch == 1) ? 12'h0F0 : 12'h00F;
  endfunction

  // mode 0 random around field, 1 digit row X0+i at Y0+3, 2 R-units row 0, 3 out-of-field list
  task automatic scan(input int mode, input int n);
    int hs [64];
    int vs [64];
    bit os [64];
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk);
      #1;
      if (i < n) begin
        case (mode)
          0: begin
            hs[i] = int'(X0) - 8 + int'($urandom_range(0, 63));
            vs[i] = int'(Y0) - 4 + int'($urandom_range(0, 103));
            os[i] = ($urandom_range(0, 7) != 0);
          end
          1: begin hs[i] = int'(X0) + i;      vs[i] = int'(Y0) + 3; os[i] = 1'b1; end
          2: begin hs[i] = int'(X0) + 32 + i; vs[i] = int'(Y0);     os[i] = 1'b1; end
          default: begin
            case (i % 4)
              0: begin hs[i] = int'(X0) + 48; vs[i] = int'(Y0);      os[i] = 1'b1; end
              1: begin hs[i] = int'(X0) - 1;  vs[i] = int'(Y0);      os[i] = 1'b1; end
              2: begin hs[i] = int'(X0) + 40; vs[i] = int'(Y0) + 16; os[i] = 1'b1; end
              default: begin hs[i] = int'(X0) + 40; vs[i] = int'(Y0) + 2; os[i] = 1'b0; end
            endcase
          end
        endcase
        hc    = 10'(hs[i]);
        vc    = 10'(vs[i]);
        vidon = os[i];
      end else begin
        vidon = 1'b0;
      end
      @(negedge clk);
      if (i >= 1 && i - 1 < n) begin
        check("digit_code", 32'(digit_code), 32'(model_addr(hs[i-1], vs[i-1]) >> 4));
        check("row_addr",   32'(row_addr),   32'(model_addr(hs[i-1], vs[i-1]) & 8'h0F));
      end
      if (i >= 2)
        check("px_rgb", 32'(px_rgb), 32'(model_px(hs[i-2], vs[i-2], os[i-2])));
    end
  endtask

  task automatic do_load(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input bit second, input int abort_at);
    int cnt = 0;
    bit aborted = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b1; val_r = r; val_g = g; val_b = b;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    while (!ready && cnt < 100) begin
      cnt++;
      if (second && cnt == 1) begin
        load = 1'b1; val_r = ~r; val_g = ~g; val_b = ~b;
      end else begin
        load = 1'b0;
      end
      if (abort_at != 0 && cnt == abort_at) begin
        clr_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_px", 32'(px_rgb), 32'd0);
        check("abort_digit", 32'(digit_code), 32'd0);
        #1;
        clr_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    load = 1'b0;
    if (aborted) begin
      exp_val[0] = 0; exp_val[1] = 0; exp_val[2] = 0;
    end else begin
      check("busy_cycles", 32'(cnt), 32'd25);
      exp_val[0] = int'(r); exp_val[1] = int'(g); exp_val[2] = int'(b);
    end
  endtask

  initial begin
    for (int d = 0; d < 16; d++)
      for (int r = 0; r < 16; r++)
        rom[d][r] = 16'($urandom);
    rom[2][3] = 16'b1110_0000_0000_0000;
    exp_val[0] = 0; exp_val[1] = 0; exp_val[2] = 0;
    clr_n = 1'b0; load = 1'b0;
    val_r = '0; val_g = '0; val_b = '0;
    hc = X0 + 10'd40; vc = Y0 + 10'd2; vidon = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_px", 32'(px_rgb), 32'd0);
    check("rst_digit", 32'(digit_code), 32'd0);
    check("rst_row", 32'(row_addr), 32'd0);
    clr_n = 1'b1;

    scan(2, 16);
    scan(0, 20);

    do_load(8'd255, 8'd128, 8'd7, 1'b0, 0);
    scan(1, 16);
    scan(0, 60);
    scan(3, 8);

    do_load(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);
    scan(0, 40);

    do_load(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 10);
    scan(2, 16);
    scan(0, 20);
    do_load(8'd99, 8'($urandom_range(0, 9)), 8'($urandom), 1'b0, 0);
    scan(0, 60);

    for (int k = 0; k < 4; k++) begin
      do_load(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
      scan(0, 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
